// File: rtl/pdts_sync_capture.sv
// rtl/pdts_sync_capture.sv - sync command capture FIFO with timestamp continuity checker
//
// Captures masked sync commands together with their arrival timestamp into a
// first-word-fall-through FIFO, and checks that the endpoint timestamp
// advances by exactly one per clock while the endpoint reports ready.
//
// Ports:
//   clk       endpoint recovered system clock
//   rst_n     asynchronous active-low reset
//   rdy       endpoint ready; sync/tstamp valid only when high
//   sync      command code
//   sync_v    command strobe
//   tstamp    endpoint timestamp
//   cmd_mask  per-command capture enable
//   clr       synchronous clear of ovf_cnt and ts_err
//   rd_en     pop head entry
//   rd_valid  FIFO non-empty
//   rd_cmd    head command (0 when empty)
//   rd_ts     head timestamp (0 when empty)
//   count     current occupancy, 0..DEPTH
//   ovf_cnt   saturating count of dropped captures
//   ts_err    sticky timestamp discontinuity flag
//   locked    timestamp continuity currently good
module pdts_sync_capture #(
    parameter int DEPTH = 16,
    parameter int CMD_W = 4,
    parameter int TS_W  = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rdy,
    input  logic [CMD_W-1:0]         sync,
    input  logic                     sync_v,
    input  logic [TS_W-1:0]          tstamp,
    input  logic [(2**CMD_W)-1:0]    cmd_mask,
    input  logic                     clr,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [CMD_W-1:0]         rd_cmd,
    output logic [TS_W-1:0]          rd_ts,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              ovf_cnt,
    output logic                     ts_err,
    output logic                     locked
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [0:0] ST_UNARMED = 1'b0;
    localparam logic [0:0] ST_ARMED   = 1'b1;

    logic [CMD_W-1:0] r_mem_cmd [DEPTH];
    logic [TS_W-1:0]  r_mem_ts  [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic [15:0]      r_ovf_cnt;

    logic [0:0]       r_state;
    logic [TS_W-1:0]  r_ts_prev;
    logic             r_ts_err;
    logic             r_locked;

    logic             w_wr_req;
    logic             w_full;
    logic             w_pop;
    logic             w_wr;
    logic             w_drop;
    logic             w_ts_match;
    logic             w_ts_mismatch;

    assign w_wr_req = rdy & sync_v & cmd_mask[sync];
    assign w_full   = (r_count == (AW+1)'(DEPTH));
    assign w_pop    = rd_en & (r_count != '0);
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign w_wr     = w_wr_req & (~w_full | w_pop);
    assign w_drop   = w_wr_req & w_full & ~w_pop;

    assign w_ts_match    = (tstamp == r_ts_prev + TS_W'(1));
    assign w_ts_mismatch = rdy & (r_state == ST_ARMED) & ~w_ts_match;

    // Storage carries no reset; outputs are gated by occupancy instead.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem_cmd[r_wptr] <= sync;
            r_mem_ts[r_wptr]  <= tstamp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A drop on the same edge as clr wins, restarting the count at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_cnt <= '0;
        end else if (w_drop) begin
            if (clr) begin
                r_ovf_cnt <= 16'd1;
            end else if (r_ovf_cnt != 16'hFFFF) begin
                r_ovf_cnt <= r_ovf_cnt + 16'd1;
            end
        end else if (clr) begin
            r_ovf_cnt <= '0;
        end
    end

    // Continuity checker: always re-latches the current timestamp, so one
    // jump produces a single mismatch and the next clean step relocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_UNARMED;
            r_ts_prev <= '0;
            r_locked  <= 1'b0;
        end else if (!rdy) begin
            r_state  <= ST_UNARMED;
            r_locked <= 1'b0;
        end else begin
            r_ts_prev <= tstamp;
            if (r_state == ST_UNARMED) begin
                r_state  <= ST_ARMED;
                r_locked <= 1'b0;
            end else begin
                r_locked <= w_ts_match;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts_err <= 1'b0;
        end else if (w_ts_mismatch) begin
            r_ts_err <= 1'b1;
        end else if (clr) begin
            r_ts_err <= 1'b0;
        end
    end

    assign rd_valid = (r_count != '0);
    assign rd_cmd   = rd_valid ? r_mem_cmd[r_rptr] : '0;
    assign rd_ts    = rd_valid ? r_mem_ts[r_rptr]  : '0;
    assign count    = r_count;
    assign ovf_cnt  = r_ovf_cnt;
    assign ts_err   = r_ts_err;
    assign locked   = r_locked;

endmodule

// File: doc/pdts_sync_capture.md
# pdts_sync_capture

Downstream consumer of the timing endpoint's decoded outputs (`rdy`, `sync`, `sync_v`, `tstamp`) in the endpoint's recovered-clock domain.
- Captures selected sync commands together with the 64-bit timestamp at which they arrived, and buffers them in a first-word-fall-through FIFO for readout by WIB logic.
- Independently checks that `tstamp` advances by exactly one per clock while the endpoint reports ready.
- Reports FIFO overflow drops and timestamp discontinuities.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `CMD_W`, 4: sync command width.
- `TS_W`, 64: timestamp width.

- `clk`  in  1  endpoint recovered system clock; sole clock.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `rdy`  in  1  endpoint ready; timestamps and commands valid only when high.
- `sync`  in  CMD_W  command code.
- `sync_v`  in  1  command strobe, one cycle per command.
- `tstamp`  in  TS_W  endpoint timestamp.
- `cmd_mask`  in  2**CMD_W  bit n=1 enables capture of command n.
- `clr`  in  1  synchronous clear of `ovf_cnt` and `ts_err`.
- `rd_en`  in  1  pop head entry.
- `rd_valid`  out  1  FIFO non-empty.
- `rd_cmd`  out  CMD_W  head command; 0 when `rd_valid`=0.
- `rd_ts`  out  TS_W  head timestamp; 0 when `rd_valid`=0.
- `count`  out  log2(DEPTH)+1  current occupancy.
- `ovf_cnt`  out  16  saturating count of dropped captures.
- `ts_err`  out  1  sticky timestamp discontinuity flag.
- `locked`  out  1  timestamp continuity currently good.

## Operation
- Capture condition: `rdy & sync_v & cmd_mask[sync]`. The written entry is {`sync`, `tstamp`} as sampled on that edge.
- `rdy`=0: no captures. FIFO contents and counters are retained.
- FIFO is first-word-fall-through. `rd_valid` = (`count`≠0). `rd_en` with `rd_valid`=1 pops the head. `rd_en` with the FIFO empty is ignored.
- Write while full (`count`=DEPTH) with no pop: the entry is dropped and `ovf_cnt` increments, saturating at 0xFFFF.
- Write and pop on the same edge while full: both occur, `count` stays at DEPTH, no drop.
- Write and `rd_en` on the same edge while empty: write occurs, pop is ignored, `count`→1.
- Pointers wrap modulo DEPTH. `count` covers 0..DEPTH inclusive.
- Continuity checker states:
  - UNARMED: on `rdy`=1, latch `tstamp` into `ts_prev`, go to ARMED. `locked`=0.
  - ARMED: each cycle compare `tstamp` with `ts_prev`+1 mod 2^TS_W.
    - Match: `locked`=1.
    - Mismatch: `ts_err`←1 (sticky), `locked`←0.
    - In both cases `ts_prev`←`tstamp`, so the checker re-syncs after a mismatch.
  - `rdy`=0 in any state: go to UNARMED, `locked`←0.
- Wrap-around: all-ones followed by zero is a match.
- `clr`: `ovf_cnt`←0 and `ts_err`←0. If a drop or mismatch occurs on the same edge, the event wins: `ovf_cnt`=1 or `ts_err`=1 respectively.
- Reset (`rst_n`=0): `count`, `rd_valid`, `rd_cmd`, `rd_ts`, `ovf_cnt`, `ts_err`, `locked` all 0; pointers 0; checker in UNARMED. Reset mid-operation discards all FIFO contents.

## Timing
- Capture sampled at edge k → `rd_valid`, `rd_cmd`, `rd_ts`, `count` updated after edge k (visible in cycle k+1).
- Pop at edge k → next head (or zeros if now empty) visible after edge k.
- Checker latency:
  - `rdy` first sampled high at edge 0 → ARMED.
  - First compare at edge 1 → `locked`=1 after edge 1 if it matches.
  - A mismatch sampled at edge m sets `ts_err`=1 and `locked`=0 after edge m.
  - A match at edge m+1 restores `locked`=1 after edge m+1.
- Single clock domain; no CDC inside the block. `cmd_mask` is sampled every edge with no shadowing.

## Test plan
- Reset, `rdy`=1, `tstamp` counting from 0x100, `cmd_mask`=0x0004, `sync_v` with `sync`=2 at `tstamp`=0x105 → next cycle `rd_valid`=1, `rd_cmd`=2, `rd_ts`=0x105. `sync`=3 strobe is not captured. `locked`=1 from the second `rdy` cycle.
- `cmd_mask`=0xFFFF, 18 captures with no reads (DEPTH=16) → `count`=16, `ovf_cnt`=2. Then 16 pops return the first 16 timestamps in order, and `rd_valid`=0 with `rd_cmd`/`rd_ts`=0.
- FIFO full, capture with simultaneous `rd_en` → `count` stays 16, `ovf_cnt` unchanged. FIFO empty, capture with `rd_en` → `count`=1.
- `tstamp` jumps 0x200→0x210 → `ts_err`=1 and `locked`=0 for one cycle, `locked`=1 again at 0x211. `clr` clears `ts_err`. `tstamp` 0xFFFF_FFFF_FFFF_FFFF→0 does not set `ts_err`.
- Drop toggling: force 0xFFFF drops → `ovf_cnt` holds at 0xFFFF. `clr` on the same edge as a drop → `ovf_cnt`=1.
- `rdy` low mid-stream → `locked`=0 and `sync_v` ignored. `rst_n` pulsed low asynchronously with 5 entries stored → all outputs 0 immediately and `count`=0.
